// File: rtl/sort_stat_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sort_stat_unit: buffers an N-value burst, checks non-decreasing order and |
// | emits sum, min, max, median serially.              Revision: 1.0         |
// +--------------------------------------------------------------------------+
module sort_stat_unit #(
  parameter int N  = 8,
  parameter int DW = 6,
  parameter int OW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in,
  output logic          out_valid,
  output logic [OW-1:0] out,
  output logic          order_err
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_buf [N];
  logic [DW-1:0] r_prev;
  logic [OW-1:0] r_sum;
  logic          r_viol;
  logic [1:0]    r_phase;

  logic          w_start, w_take, w_last, w_viol_nxt;
  logic [OW-1:0] w_sum_nxt;
  logic [DW-1:0] w_min, w_max;
  logic [DW:0]   w_mid_sum;
  logic          w_valid_nxt, w_err_nxt;
  logic [OW-1:0] w_out_nxt;

  assign w_start    = (r_state == S_IDLE) && in_valid;
  assign w_take     = (r_state == S_COLLECT) && in_valid;
  assign w_last     = w_take && (r_count == C_LAST);
  assign w_sum_nxt  = r_sum + OW'(in);
  assign w_viol_nxt = r_viol | (in < r_prev);
  assign w_mid_sum  = {1'b0, r_buf[N/2-1]} + {1'b0, r_buf[N/2]};

  // Min/max scan over the full buffer; only consumed once the burst is complete.
  always_comb begin
    w_min = r_buf[0];
    w_max = r_buf[0];
    for (int i = 1; i < N; i++) begin
      if (r_buf[i] < w_min) w_min = r_buf[i];
      if (r_buf[i] > w_max) w_max = r_buf[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (!in_valid)             w_state_nxt = S_IDLE;
        else if (r_count == C_LAST) w_state_nxt = S_EMIT;
      end
      S_EMIT:    if (r_phase == 2'd3) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next registered output: the sum is launched on the edge that captures the
  // last value, each later EMIT phase launches the following statistic.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_out_nxt   = '0;
    w_err_nxt   = 1'b0;
    if (w_last) begin
      w_valid_nxt = 1'b1;
      w_out_nxt   = w_sum_nxt;
      w_err_nxt   = w_viol_nxt;
    end else if ((r_state == S_EMIT) && (r_phase != 2'd3)) begin
      w_valid_nxt = 1'b1;
      w_err_nxt   = r_viol;
      case (r_phase)
        2'd0:    w_out_nxt = OW'(w_min);
        2'd1:    w_out_nxt = OW'(w_max);
        default: w_out_nxt = OW'(w_mid_sum[DW:1]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      order_err <= 1'b0;
      r_count   <= '0;
      r_prev    <= '0;
      r_sum     <= '0;
      r_viol    <= 1'b0;
      r_phase   <= '0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      out_valid <= w_valid_nxt;
      out       <= w_out_nxt;
      order_err <= w_err_nxt;
      if (w_start) begin
        r_buf[0] <= in;
        r_count  <= CW'(1);
        r_prev   <= in;
        r_sum    <= OW'(in);
        r_viol   <= 1'b0;
        r_phase  <= '0;
      end else if (w_take) begin
        r_buf[r_count[IW-1:0]] <= in;
        r_count <= w_last ? '0 : r_count + CW'(1);
        r_prev  <= in;
        r_sum   <= w_sum_nxt;
        r_viol  <= w_viol_nxt;
      end else if (r_state == S_COLLECT) begin
        r_count <= '0;
      end
      if (r_state == S_EMIT) r_phase <= r_phase + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_stat_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sort_stat_unit: table vectors, corner sequences and random bursts     |
// | against a sort-based reference model.              Revision: 1.0         |
// +--------------------------------------------------------------------------+
module tb_sort_stat_unit;

  localparam int N  = 8;
  localparam int DW = 6;
  localparam int OW = 9;

  typedef struct packed {
    logic [N-1:0][DW-1:0] v;
    logic [3:0][OW-1:0]   e;
    logic                 err;
    logic                 pulse;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] din;
  logic          out_valid;
  logic [OW-1:0] out;
  logic          order_err;

  int n_checks = 0;
  int n_errors = 0;

  sort_stat_unit #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (din),
    .out_valid (out_valid),
    .out       (out),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7,
                              input int s, mn, mx, md, input bit err, input bit pulse);
    vec_t r;
    r.v[0] = DW'(a0); r.v[1] = DW'(a1); r.v[2] = DW'(a2); r.v[3] = DW'(a3);
    r.v[4] = DW'(a4); r.v[5] = DW'(a5); r.v[6] = DW'(a6); r.v[7] = DW'(a7);
    r.e[0] = OW'(s);  r.e[1] = OW'(mn); r.e[2] = OW'(mx); r.e[3] = OW'(md);
    r.err = err;
    r.pulse = pulse;
    return r;
  endfunction

  // Reference: a burst is in order iff it equals its own sorted copy.
  function automatic void model(input logic [N-1:0][DW-1:0] v,
                                output logic [3:0][OW-1:0] e, output logic err);
    int q[$];
    int s = 0;
    for (int k = 0; k < N; k++) begin
      q.push_back(int'(v[k]));
      s += int'(v[k]);
    end
    e[3] = OW'((q[N/2-1] + q[N/2]) / 2);
    q.sort();
    err = 1'b0;
    for (int k = 0; k < N; k++) if (q[k] != int'(v[k])) err = 1'b1;
    e[0] = OW'(s);
    e[1] = OW'(q[0]);
    e[2] = OW'(q[N-1]);
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic drive_burst(input logic [N-1:0][DW-1:0] v);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      din      = v[k];
      @(negedge clk);
      check("collect_out_valid", OW'(out_valid), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    din      = '0;
  endtask

  task automatic check_emit(input logic [3:0][OW-1:0] e, input logic err, input bit pulse);
    for (int p = 0; p < 4; p++) begin
      if (pulse) begin
        in_valid = 1'b1;
        din      = DW'($urandom);
      end
      @(negedge clk);
      check($sformatf("emit%0d_valid", p), OW'(out_valid), 1);
      check($sformatf("emit%0d_out", p), out, e[p]);
      check($sformatf("emit%0d_err", p), OW'(order_err), OW'(err));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    din      = '0;
    @(negedge clk);
    check("post_valid", OW'(out_valid), 0);
    check("post_out", out, 0);
    check("post_err", OW'(order_err), 0);
    @(posedge clk); #1;
  endtask

  vec_t                 tbl[4];
  logic [N-1:0][DW-1:0] rv;
  logic [3:0][OW-1:0]   re;
  logic                 rerr;

  initial begin
    tbl[0] = mk(2, 5, 5, 9, 12, 20, 31, 60,       144, 2, 60, 10, 1'b0, 1'b0);
    tbl[1] = mk(30, 1, 7, 7, 8, 40, 3, 2,         98, 1, 40, 7,   1'b1, 1'b0);
    tbl[2] = mk(63, 63, 63, 63, 63, 63, 63, 63,   504, 63, 63, 63, 1'b0, 1'b1);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,     1'b0, 1'b1);

    rst_n    = 1'b0;
    in_valid = 1'b0;
    din      = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_valid", OW'(out_valid), 0);
      check("reset_out", out, 0);
      check("reset_err", OW'(order_err), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      drive_burst(tbl[i].v);
      check_emit(tbl[i].e, tbl[i].err, tbl[i].pulse);
    end

    // Partial burst aborted by a one-cycle gap; the next burst must restart at slot 0.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      din      = DW'(k * 7 + 3);
      @(negedge clk);
      check("abort_collect_valid", OW'(out_valid), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_gap_valid", OW'(out_valid), 0);
    @(posedge clk); #1;
    rv = '0;
    for (int k = 0; k < N; k++) rv[k] = DW'(10);
    drive_burst(rv);
    re[0] = OW'(80); re[1] = OW'(10); re[2] = OW'(10); re[3] = OW'(10);
    check_emit(re, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int q[$];
      int mode;
      mode = $urandom_range(0, 2);
      q.delete();
      for (int k = 0; k < N; k++)
        q.push_back((mode == 2) ? $urandom_range(0, 3) : $urandom_range(0, 63));
      if (mode != 0) q.sort();
      for (int k = 0; k < N; k++) rv[k] = DW'(q[k]);
      model(rv, re, rerr);
      drive_burst(rv);
      check_emit(re, rerr, bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of EMIT phase 1.
    for (int k = 0; k < N; k++) rv[k] = DW'(40 - 3 * k);
    drive_burst(rv);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", OW'(out_valid), 0);
    check("midreset_out", out, 0);
    check("midreset_err", OW'(order_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("after_reset_valid", OW'(out_valid), 0);
      check("after_reset_out", out, 0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < N; k++) rv[k] = DW'(k + 1);
    drive_burst(rv);
    re[0] = OW'(36); re[1] = OW'(1); re[2] = OW'(8); re[3] = OW'(4);
    check_emit(re, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_stat_unit.md
Name: sort_stat_unit

Overview:
- Downstream consumer of the rotate/add/sort stage. Takes that stage's 8-value sorted burst (6-bit sums, one per cycle, qualified by a valid strobe).
- Buffers the burst, checks that it is non-decreasing, then emits four statistics serially: sum, min, max, median.
- Output is 9 bits wide, qualified by out_valid, with an order-error flag.

Parameters:
- N, 8, burst length in values (design and bench are exercised at N=8 only).
- DW, 6, input value width.
- OW, 9, output width; must satisfy OW >= DW + log2(N).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  high for each valid burst value; a burst is exactly N consecutive high cycles.
- in  input  DW  burst value; sampled only when in_valid=1.
- out_valid  output  1  high for exactly 4 consecutive cycles per accepted burst.
- out  output  OW  statistic; must be 0 whenever out_valid=0.
- order_err  output  1  high during all 4 output cycles if the burst was not non-decreasing; 0 otherwise.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n. All state and outputs clear immediately on reset assertion: out_valid=0, out=0, order_err=0, FSM=IDLE, count=0, buffer=0.
- All outputs are registered.
- FSM states: IDLE, COLLECT, EMIT.
- IDLE, in_valid=1: store value in buf[0], count<=1, go to COLLECT.
- COLLECT, in_valid=1: store value in buf[count] and increment count.
- COLLECT, when the N-th value is stored: go to EMIT.
- COLLECT, in_valid=0 before N values:
  - abort and discard the partial burst; go to IDLE with count=0.
  - no output, no err.
  - a later in_valid starts a fresh burst at buf[0].
- Order check:
  - on each stored value k>0, compare against buf[k-1]. Equal values are legal.
  - if in < previous, set a sticky violation bit; the bit clears at burst start.
- EMIT: 4 cycles, phase 0..3.
  - First out_valid=1 is on the cycle after the clock edge that captured the N-th value (latency 1).
  - phase0 out = sum of all N values, zero-extended, no overflow (max 8*63=504).
  - phase1 out = min of buffer, computed by scan, not assumed to be buf[0].
  - phase2 out = max of buffer, computed by scan.
  - phase3 out = floor((buf[3]+buf[4])/2), i.e. the median of positions 3 and 4 as received, regardless of the order flag.
  - order_err equals the sticky violation bit for all 4 phases.
  - After phase3: out_valid=0, out=0, order_err=0; return to IDLE.
- in_valid=1 during EMIT: ignored and dropped, with no effect on the current output or on the next burst.
- A new burst is accepted from the cycle after phase3. Back-to-back bursts separated by 1 idle cycle must work.
- Reset asserted mid-COLLECT or mid-EMIT: outputs drop to 0 immediately; no residual output after release.
- Sum and min/max may be computed incrementally during COLLECT or in EMIT. The only requirement is the cycle timing above.

Test Plan:
- Reset check: assert rst_n=0 with in_valid=0 → out=0, out_valid=0, order_err=0 immediately and while held; none of them goes X.
- Sorted burst 2,5,5,9,12,20,31,60 → 1 cycle later, 4 valid cycles out = 144, 2, 60, 10; order_err=0; then out_valid=0, out=0.
- Unsorted burst 30,1,7,7,8,40,3,2 → out = 98, 1, 40, 7 (floor 15/2); order_err=1 on all 4 cycles.
- Abort: 5 values then in_valid=0 for 1 cycle, then full burst 10,10,10,10,10,10,10,10 → single output sequence 80, 10, 10, 10; no output from the partial burst.
- Extremes: all 63 → 504, 63, 63, 63. All 0 → 0, 0, 0, 0 with out_valid=1 for 4 cycles. In both cases in_valid pulses during EMIT are ignored.
- Reset mid-EMIT at phase1: outputs clear asynchronously. After release, the next burst 1..8 produces 36, 1, 8, 4 with correct latency.
